// File: rtl/packet_rr_scheduler.sv
// packet_rr_scheduler: per-master round-robin ownership FSMs that drive the one-hot crossbar grant matrix
module packet_rr_scheduler #(
  parameter int S_DATA_COUNT = 5,
  parameter int M_DATA_COUNT = 3,
  parameter int T_ID___WIDTH = $clog2(S_DATA_COUNT),
  parameter int T_DEST_WIDTH = $clog2(M_DATA_COUNT)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [T_DEST_WIDTH*S_DATA_COUNT-1:0] s_dest_i,
  input  logic [S_DATA_COUNT-1:0]              s_valid_i,
  input  logic [S_DATA_COUNT-1:0]              s_last_i,
  output logic [S_DATA_COUNT-1:0]              s_ready_o,
  input  logic [M_DATA_COUNT-1:0]              m_ready_i,
  output logic [M_DATA_COUNT-1:0]              m_valid_o,
  output logic [M_DATA_COUNT-1:0]              m_last_o,
  output logic [T_ID___WIDTH*M_DATA_COUNT-1:0] m_id_o,
  output logic [S_DATA_COUNT*M_DATA_COUNT-1:0] grant_o
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q [M_DATA_COUNT];
  state_t state_d [M_DATA_COUNT];
  logic [M_DATA_COUNT-1:0][T_ID___WIDTH-1:0] owner_q, owner_d, ptr_q, ptr_d;
  logic [M_DATA_COUNT-1:0][S_DATA_COUNT-1:0] req;
  logic [M_DATA_COUNT-1:0] done;
  logic [S_DATA_COUNT-1:0] owned;
  always_comb begin
    owned = '0;
    for (int j = 0; j < M_DATA_COUNT; j++)
      if (state_q[j] == BUSY) owned[owner_q[j]] = 1'b1;
  end
  // A slave already owning a master cannot request another, so no grant row ever holds two ones
  always_comb begin
    req = '0;
    for (int j = 0; j < M_DATA_COUNT; j++)
      for (int i = 0; i < S_DATA_COUNT; i++)
        req[j][i] = s_valid_i[i] && !owned[i] &&
                    s_dest_i[i*T_DEST_WIDTH +: T_DEST_WIDTH] == T_DEST_WIDTH'(j);
  end
  always_comb begin
    done = '0;
    for (int j = 0; j < M_DATA_COUNT; j++)
      done[j] = state_q[j] == BUSY && m_ready_i[j] &&
                s_valid_i[owner_q[j]] && s_last_i[owner_q[j]];
  end
  // Scanning downward lets the nearest requester at or above ptr win the last overwrite
  always_comb begin
    for (int j = 0; j < M_DATA_COUNT; j++) begin
      state_d[j] = state_q[j];
      owner_d[j] = owner_q[j];
      ptr_d[j]   = ptr_q[j];
      if (state_q[j] == IDLE) begin
        for (int k = S_DATA_COUNT - 1; k >= 0; k--)
          if (req[j][(int'(ptr_q[j]) + k) % S_DATA_COUNT]) begin
            state_d[j] = BUSY;
            owner_d[j] = T_ID___WIDTH'((int'(ptr_q[j]) + k) % S_DATA_COUNT);
          end
      end else if (done[j]) begin
        state_d[j] = IDLE;
        ptr_d[j]   = owner_q[j] == T_ID___WIDTH'(S_DATA_COUNT - 1) ? '0 : owner_q[j] + 1'b1;
      end
    end
  end
  always_comb begin
    grant_o   = '0;
    m_valid_o = '0;
    m_last_o  = '0;
    m_id_o    = '0;
    s_ready_o = '0;
    for (int j = 0; j < M_DATA_COUNT; j++)
      if (state_q[j] == BUSY) begin
        grant_o[j*S_DATA_COUNT + int'(owner_q[j])] = 1'b1;
        m_valid_o[j]                               = s_valid_i[owner_q[j]];
        m_last_o[j]                                = s_last_i[owner_q[j]];
        m_id_o[j*T_ID___WIDTH +: T_ID___WIDTH]     = owner_q[j];
        s_ready_o[owner_q[j]]                      = m_ready_i[j];
      end
  end
  always_ff @(posedge clk)
    for (int j = 0; j < M_DATA_COUNT; j++) begin
      state_q[j] <= rst ? IDLE : state_d[j];
      owner_q[j] <= rst ? '0 : owner_d[j];
      ptr_q[j]   <= rst ? '0 : ptr_d[j];
    end
endmodule

// File: tb/tb_packet_rr_scheduler.sv
// tb_packet_rr_scheduler: scenario tasks with a beat scoreboard for packet_rr_scheduler
module tb_packet_rr_scheduler;
  localparam int S = 5, M = 3, TI = 3, TD = 2;
  logic clk = 1'b0, rst = 1'b1;
  logic [TD*S-1:0] s_dest;
  logic [S-1:0] s_valid, s_last, s_ready;
  logic [M-1:0] m_ready, m_valid, m_last;
  logic [TI*M-1:0] m_id;
  logic [S*M-1:0] grant;
  typedef struct {int m; int id; bit last;} beat_t;
  beat_t sb[$];
  int pk[S], ln[S], rm[S], ds[S];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  packet_rr_scheduler #(.S_DATA_COUNT(S), .M_DATA_COUNT(M)) dut (
    .clk(clk), .rst(rst), .s_dest_i(s_dest), .s_valid_i(s_valid), .s_last_i(s_last),
    .s_ready_o(s_ready), .m_ready_i(m_ready), .m_valid_o(m_valid), .m_last_o(m_last),
    .m_id_o(m_id), .grant_o(grant));
  task automatic apply();
    for (int i = 0; i < S; i++) begin
      s_valid[i] = pk[i] > 0;
      s_last[i] = rm[i] == 1;
      s_dest[i*TD +: TD] = TD'(ds[i]);
    end
  endtask
  task automatic launch(input int i, input int d, input int l, input int n);
    ds[i] = d; ln[i] = l; rm[i] = l; pk[i] = n;
    apply();
  endtask
  task automatic push(input int m, input int id, input bit last);
    beat_t b;
    b.m = m; b.id = id; b.last = last;
    sb.push_back(b);
  endtask
  // Runs at the falling edge: scores master beats and advances the slave sources
  task automatic mon();
    beat_t e;
    for (int j = 0; j < M; j++)
      if (m_valid[j] && m_ready[j]) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL beat m%0d: got id %0d last %0d, expected no beat", j, m_id[j*TI +: TI], m_last[j]);
        end else begin
          e = sb.pop_front();
          if (e.m !== j || e.id !== int'(m_id[j*TI +: TI]) || e.last !== m_last[j]) begin
            errors++;
            $display("FAIL beat: got m%0d id %0d last %0d, expected m%0d id %0d last %0d",
                     j, m_id[j*TI +: TI], m_last[j], e.m, e.id, e.last);
          end
        end
      end
    for (int i = 0; i < S; i++)
      if (s_valid[i] && s_ready[i]) begin
        rm[i]--;
        if (rm[i] == 0) begin pk[i]--; rm[i] = ln[i]; end
      end
  endtask
  task automatic adv();
    mon();
    @(posedge clk); #1;
    apply();
  endtask
  task automatic cyc();
    @(negedge clk);
    adv();
  endtask
  task automatic rst_dut();
    rst = 1'b1;
    for (int i = 0; i < S; i++) begin pk[i] = 0; rm[i] = 0; ln[i] = 1; ds[i] = 0; end
    apply();
    m_ready = '1;
    sb.delete();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask
  task automatic drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || pk[0] + pk[1] + pk[2] + pk[3] + pk[4] != 0) && n < 40) begin cyc(); n++; end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL %s drain: %0d beats outstanding, expected 0", name, sb.size()); end
    cyc();
  endtask
  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < S; i++) begin pk[i] = 1; rm[i] = 1; ln[i] = 1; ds[i] = i % M; end
    apply();
    m_ready = '1;
    @(posedge clk); @(negedge clk);
    checks++;
    if (grant !== '0 || m_valid !== '0 || s_ready !== '0) begin errors++;
      $display("FAIL reset outputs: grant %h valid %b ready %b, expected 0", grant, m_valid, s_ready); end
    checks++;
    if (m_id !== '0 || m_last !== '0) begin errors++; $display("FAIL reset id/last: id %h last %b, expected 0", m_id, m_last); end
    rst_dut();
  endtask
  task automatic test_single();
    rst_dut();
    launch(2, 1, 3, 1);
    push(1, 2, 0); push(1, 2, 0); push(1, 2, 1);
    @(negedge clk);
    checks++;
    if (grant !== '0) begin errors++; $display("FAIL single latency: grant %h, expected 0", grant); end
    adv();
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      checks++;
      if (grant !== 15'(1 << 7)) begin errors++; $display("FAIL single grant beat %0d: %h, expected %h", b, grant, 15'(1 << 7)); end
      checks++;
      if (m_id !== 9'(2 << 3)) begin errors++; $display("FAIL single id: %h, expected %h", m_id, 9'(2 << 3)); end
      checks++;
      if (m_last[1] !== (b == 2)) begin errors++; $display("FAIL single last beat %0d: %b, expected %b", b, m_last[1], b == 2); end
      adv();
    end
    @(negedge clk);
    checks++;
    if (grant[5 +: 5] !== '0) begin errors++; $display("FAIL single release: column %b, expected 0", grant[5 +: 5]); end
    adv();
    drain("single");
  endtask
  task automatic test_rr();
    int exp_id[6] = '{0, 1, 4, 0, 1, 4};
    rst_dut();
    launch(0, 0, 1, 2); launch(1, 0, 1, 2); launch(4, 0, 1, 2);
    for (int k = 0; k < 6; k++) push(0, exp_id[k], 1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (grant !== '0) begin errors++; $display("FAIL rr bubble %0d: grant %h, expected 0", k, grant); end
      adv();
      @(negedge clk);
      checks++;
      if (grant !== 15'(1) << exp_id[k]) begin errors++; $display("FAIL rr grant %0d: %h, expected %h", k, grant, 15'(1) << exp_id[k]); end
      adv();
    end
    drain("rr");
  endtask
  task automatic test_hold();
    rst_dut();
    launch(3, 2, 3, 1);
    push(2, 3, 0);
    @(negedge clk); adv();
    @(negedge clk);
    checks++;
    if (grant !== 15'(1 << 13)) begin errors++; $display("FAIL hold first: grant %h, expected %h", grant, 15'(1 << 13)); end
    adv();
    m_ready[2] = 1'b0;
    launch(1, 2, 1, 1);
    push(2, 3, 0); push(2, 3, 1); push(2, 1, 1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (s_ready[3] !== 1'b0 || grant !== 15'(1 << 13)) begin errors++;
        $display("FAIL hold stall %0d: ready3 %b grant %h, expected 0 and %h", c, s_ready[3], grant, 15'(1 << 13)); end
      adv();
    end
    m_ready[2] = 1'b1;
    @(negedge clk);
    checks++;
    if (grant !== 15'(1 << 13) || s_ready[3] !== 1'b1) begin errors++;
      $display("FAIL hold resume: grant %h ready3 %b, expected %h and 1", grant, s_ready[3], 15'(1 << 13)); end
    adv();
    @(negedge clk);
    checks++;
    if (m_last[2] !== 1'b1) begin errors++; $display("FAIL hold last: %b, expected 1", m_last[2]); end
    adv();
    @(negedge clk);
    checks++;
    if (grant !== '0) begin errors++; $display("FAIL hold bubble: grant %h, expected 0", grant); end
    adv();
    @(negedge clk);
    checks++;
    if (grant !== 15'(1 << 11)) begin errors++; $display("FAIL hold next owner: grant %h, expected %h", grant, 15'(1 << 11)); end
    adv();
    drain("hold");
  endtask
  task automatic test_oor();
    rst_dut();
    launch(0, 3, 1, 1);
    launch(2, 1, 1, 1);
    push(1, 2, 1);
    @(negedge clk); adv();
    @(negedge clk);
    checks++;
    if (grant !== 15'(1 << 7) || s_ready[0] !== 1'b0) begin errors++;
      $display("FAIL oor neighbour: grant %h ready0 %b, expected %h and 0", grant, s_ready[0], 15'(1 << 7)); end
    adv();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (grant !== '0 || s_ready[0] !== 1'b0) begin errors++;
        $display("FAIL oor idle %0d: grant %h ready0 %b, expected 0", c, grant, s_ready[0]); end
      adv();
    end
    pk[0] = 0;
    apply();
    drain("oor");
  endtask
  task automatic test_parallel();
    rst_dut();
    launch(0, 0, 1, 1); launch(4, 2, 1, 1);
    push(0, 0, 1); push(2, 4, 1);
    @(negedge clk); adv();
    @(negedge clk);
    checks++;
    if (grant !== 15'h4001 || m_valid !== 3'b101) begin errors++;
      $display("FAIL parallel: grant %h valid %b, expected 4001 and 101", grant, m_valid); end
    adv();
    drain("parallel");
  endtask
  task automatic test_reset_mid();
    rst_dut();
    launch(3, 1, 1, 1);
    push(1, 3, 1);
    drain("ptr setup");
    launch(1, 1, 4, 1);
    push(1, 1, 0);
    @(negedge clk); adv();
    @(negedge clk);
    checks++;
    if (grant !== 15'(1 << 6)) begin errors++; $display("FAIL mid grant: %h, expected %h", grant, 15'(1 << 6)); end
    adv();
    rst = 1'b1;
    push(1, 1, 0);
    @(negedge clk); adv();
    rst = 1'b0;
    launch(4, 1, 1, 1);
    @(negedge clk);
    checks++;
    if (grant !== '0 || m_valid !== '0 || s_ready !== '0) begin errors++;
      $display("FAIL mid reset: grant %h valid %b ready %b, expected 0", grant, m_valid, s_ready); end
    push(1, 1, 0); push(1, 1, 1); push(1, 4, 1);
    adv();
    @(negedge clk);
    checks++;
    if (grant !== 15'(1 << 6)) begin errors++; $display("FAIL mid rearb: grant %h, expected %h", grant, 15'(1 << 6)); end
    adv();
    drain("reset_mid");
  endtask
  initial begin
    m_ready = '1;
    test_reset();
    test_single();
    test_rr();
    test_hold();
    test_oor();
    test_parallel();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
